// File: rtl/intr_ctrl.sv
// intr_ctrl -- memory-mapped interrupt controller with fixed priority.
//
// Collects NIRQ active-high device interrupt lines into a pending register,
// masks them, and raises a single registered INTR to the CPU. The CPU claims
// the highest-priority active source with a one-cycle IACK pulse, reads the
// source ID from ICLAIM, and ends service with a write to IEOI.
//
// Register window (word offsets from BASE):
//   +0  IPEND  R / write-1-to-clear
//   +4  IMASK  R/W, bit set = source enabled
//   +8  ICLAIM R only: bit BITS-1 = valid, bits 3:0 = in-service ID
//   +12 IEOI   W only, data ignored
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST_N in   asynchronous active-low reset
//   ABUS  in   [BITS-1:0] address
//   DBUS  io   [BITS-1:0] data; driven only on reads of IPEND/IMASK/ICLAIM
//   WE    in   write strobe
//   IRQ   in   [NIRQ-1:0] device interrupt lines
//   IACK  in   one-cycle CPU acknowledge
//   INTR  out  interrupt request to the CPU (registered)
//
// Build option:
//   INTC_EDGE_EN  defined   -> a pending bit sets on a 0->1 edge of its line
//                 undefined -> a pending bit sets every cycle its line is high

module intr_ctrl #(
  parameter int              BITS = 32,
  parameter logic [BITS-1:0] BASE = 32'hFFFFF200,
  parameter int              NIRQ = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  input  logic            WE,
  input  logic [NIRQ-1:0] IRQ,
  input  logic            IACK,
  output logic            INTR
);

  localparam logic [BITS-1:0] A_PEND  = BASE;
  localparam logic [BITS-1:0] A_MASK  = BASE + BITS'(4);
  localparam logic [BITS-1:0] A_CLAIM = BASE + BITS'(8);
  localparam logic [BITS-1:0] A_EOI   = BASE + BITS'(12);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          state_q;
  logic            intr_q;
  logic            valid_q;
  logic [3:0]      id_q;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] mask_q, mask_d;

  logic [NIRQ-1:0] set_vec;
  logic [NIRQ-1:0] w1c_vec;
  logic [NIRQ-1:0] claim_oh;
  logic [NIRQ-1:0] active;
  logic [3:0]      hi_id;
  logic            claim_fire;
  logic            eoi_wr;
  logic            sel_pend, sel_mask, sel_claim, sel_eoi;
  logic            rd_en;
  logic [BITS-1:0] rd_data;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  function automatic logic [3:0] prio_id(input logic [NIRQ-1:0] vec);
    logic [3:0] id;
    id = 4'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (vec[i]) id = 4'(i);
    end
    return id;
  endfunction

  // Address decode and bus strobes
  assign sel_pend  = (ABUS == A_PEND);
  assign sel_mask  = (ABUS == A_MASK);
  assign sel_claim = (ABUS == A_CLAIM);
  assign sel_eoi   = (ABUS == A_EOI);
  assign eoi_wr    = WE && sel_eoi;

  assign active     = pend_q & mask_q;
  assign hi_id      = prio_id(active);
  assign claim_fire = (state_q == S_ASSERT) && IACK && (|active);

`ifdef INTC_EDGE_EN
  logic [NIRQ-1:0] irq_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) irq_q <= '0;
    else        irq_q <= IRQ;
  end

  assign set_vec = IRQ & ~irq_q;
`else
  assign set_vec = IRQ;
`endif

  always_comb begin
    w1c_vec  = '0;
    claim_oh = '0;
    mask_d   = mask_q;
    if (WE && sel_pend) w1c_vec = DBUS[NIRQ-1:0];
    if (WE && sel_mask) mask_d  = DBUS[NIRQ-1:0];
    for (int i = 0; i < NIRQ; i++) begin
      claim_oh[i] = claim_fire && (hi_id == 4'(i));
    end
    // A set event in the same cycle as a clear keeps the bit set.
    pend_d = (pend_q & ~(w1c_vec | claim_oh)) | set_vec;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // Claim FSM; INTR is registered and high only while in S_ASSERT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      intr_q  <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|active) begin
            state_q <= S_ASSERT;
            intr_q  <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (claim_fire) begin
            state_q <= S_SERVICE;
            intr_q  <= 1'b0;
            valid_q <= 1'b1;
            id_q    <= hi_id;
          end else if (!(|active)) begin
            state_q <= S_IDLE;
            intr_q  <= 1'b0;
          end
        end
        S_SERVICE: begin
          // New pending bits wait here until the CPU signals end of service.
          if (eoi_wr) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign INTR = intr_q;

  // Combinational read mux; unused bits read as zero.
  always_comb begin
    rd_data = '0;
    if (sel_pend) begin
      rd_data[NIRQ-1:0] = pend_q;
    end else if (sel_mask) begin
      rd_data[NIRQ-1:0] = mask_q;
    end else if (sel_claim) begin
      rd_data[BITS-1] = valid_q;
      rd_data[3:0]    = id_q;
    end
  end

  assign rd_en = !WE && (sel_pend || sel_mask || sel_claim);
  assign DBUS  = rd_en ? rd_data : {BITS{1'bz}};

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  localparam logic [31:0] BASE    = 32'hFFFFF200;
  localparam logic [31:0] A_PEND  = BASE;
  localparam logic [31:0] A_MASK  = BASE + 32'd4;
  localparam logic [31:0] A_CLAIM = BASE + 32'd8;
  localparam logic [31:0] A_EOI   = BASE + 32'd12;

  logic        CLK;
  logic        RST_N;
  logic [31:0] ABUS;
  wire  [31:0] DBUS;
  logic        WE;
  logic [3:0]  IRQ;
  logic        IACK;
  logic        INTR;

  logic        tb_drv;
  logic [31:0] tb_dat;
  logic [31:0] rd;
  int          total;
  int          bad;

  assign DBUS = tb_drv ? tb_dat : {32{1'bz}};

  intr_ctrl #(.BITS(32), .BASE(32'hFFFFF200), .NIRQ(4)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .ABUS (ABUS),
    .DBUS (DBUS),
    .WE   (WE),
    .IRQ  (IRQ),
    .IACK (IACK),
    .INTR (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    ABUS   = addr;
    tb_dat = data;
    tb_drv = 1'b1;
    WE     = 1'b1;
    step();
    WE     = 1'b0;
    tb_drv = 1'b0;
    ABUS   = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    ABUS = addr;
    WE   = 1'b0;
    #1;
    data = DBUS;
    ABUS = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    RST_N  = 1'b0;
    ABUS   = 32'h0;
    WE     = 1'b0;
    IRQ    = 4'h0;
    IACK   = 1'b0;
    tb_drv = 1'b0;
    tb_dat = 32'h0;

    // Reset state
    #12;
    bus_read(A_PEND, rd);  check("rst_ipend", rd, 32'h0);
    bus_read(A_MASK, rd);  check("rst_imask", rd, 32'h0);
    bus_read(A_CLAIM, rd); check("rst_iclaim", rd, 32'h0);
    check("rst_intr", {31'h0, INTR}, 32'h0);
    RST_N = 1'b1;
    step();

    // Basic flow
    bus_write(A_MASK, 32'h1);
    bus_read(A_MASK, rd);  check("basic_imask", rd, 32'h1);
    IRQ = 4'b0001;
    step();
    IRQ = 4'b0000;
    bus_read(A_PEND, rd);  check("basic_pend_n1", rd, 32'h1);
    check("basic_intr_n1", {31'h0, INTR}, 32'h0);
    step();
    check("basic_intr_n2", {31'h0, INTR}, 32'h1);
    IACK = 1'b1;
    step();
    IACK = 1'b0;
    check("basic_intr_svc", {31'h0, INTR}, 32'h0);
    bus_read(A_CLAIM, rd); check("basic_claim", rd, 32'h80000000);
    bus_read(A_PEND, rd);  check("basic_pend_clr", rd, 32'h0);
    bus_write(A_EOI, 32'h0);
    bus_read(A_CLAIM, rd); check("basic_eoi_claim", rd, 32'h0);
    step();
    check("basic_idle_intr", {31'h0, INTR}, 32'h0);

    // Priority
    bus_write(A_MASK, 32'hF);
    IRQ = 4'b1010;
    step();
    IRQ = 4'b0000;
    bus_read(A_PEND, rd);  check("prio_pend", rd, 32'hA);
    step();
    check("prio_intr", {31'h0, INTR}, 32'h1);
    IACK = 1'b1;
    step();
    IACK = 1'b0;
    bus_read(A_CLAIM, rd); check("prio_claim1", rd, 32'h80000001);
    bus_read(A_PEND, rd);  check("prio_pend_left", rd, 32'h8);
    check("prio_intr_svc", {31'h0, INTR}, 32'h0);
    bus_write(A_EOI, 32'h0);
    check("prio_intr_eoi", {31'h0, INTR}, 32'h0);
    step();
    check("prio_intr_reassert", {31'h0, INTR}, 32'h1);
    IACK = 1'b1;
    step();
    IACK = 1'b0;
    bus_read(A_CLAIM, rd); check("prio_claim3", rd, 32'h80000003);
    bus_read(A_PEND, rd);  check("prio_pend_empty", rd, 32'h0);
    bus_write(A_EOI, 32'h0);

    // Masking
    bus_write(A_MASK, 32'h0);
    IRQ = 4'b0100;
    step();
    IRQ = 4'b0000;
    step();
    step();
    bus_read(A_PEND, rd);  check("mask_pend", rd, 32'h4);
    check("mask_intr_off", {31'h0, INTR}, 32'h0);
    bus_write(A_MASK, 32'h4);
    check("mask_intr_wr", {31'h0, INTR}, 32'h0);
    step();
    check("mask_intr_on", {31'h0, INTR}, 32'h1);
    bus_write(A_MASK, 32'h0);
    step();
    check("mask_intr_drop", {31'h0, INTR}, 32'h0);
    bus_read(A_PEND, rd);  check("mask_pend_kept", rd, 32'h4);
    bus_write(A_PEND, 32'h4);
    bus_read(A_PEND, rd);  check("mask_w1c", rd, 32'h0);

    // Simultaneous set and W1C on the same bit
    IRQ = 4'b0001;
    bus_write(A_PEND, 32'h1);
    IRQ = 4'b0000;
    bus_read(A_PEND, rd);  check("setclr_keep", rd, 32'h1);
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, rd);  check("setclr_cleared", rd, 32'h0);

    // Line held high while software keeps clearing
    IRQ = 4'b0001;
    step();
    bus_read(A_PEND, rd);  check("hold_pend_set", rd, 32'h1);
    for (int k = 0; k < 9; k++) begin
      bus_write(A_PEND, 32'h1);
      bus_read(A_PEND, rd);
`ifdef INTC_EDGE_EN
      check("hold_w1c_edge", rd, 32'h0);
`else
      check("hold_w1c_level", rd, 32'h1);
`endif
    end
    IRQ = 4'b0000;
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, rd);  check("hold_released", rd, 32'h0);

    // Asynchronous reset in the middle of service
    bus_write(A_MASK, 32'h1);
    IRQ = 4'b0001;
    step();
    IRQ = 4'b0000;
    step();
    check("rstsvc_intr_pre", {31'h0, INTR}, 32'h1);
    IACK = 1'b1;
    step();
    IACK = 1'b0;
    bus_read(A_CLAIM, rd); check("rstsvc_claim_pre", rd, 32'h80000000);
    #2;
    RST_N = 1'b0;
    #1;
    check("rstsvc_intr", {31'h0, INTR}, 32'h0);
    bus_read(A_CLAIM, rd); check("rstsvc_claim", rd, 32'h0);
    bus_read(A_MASK, rd);  check("rstsvc_mask", rd, 32'h0);
    bus_read(A_PEND, rd);  check("rstsvc_pend", rd, 32'h0);
    RST_N = 1'b1;
    step();
    step();
    check("rstsvc_idle_intr", {31'h0, INTR}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
